// File: rtl/hex_page_pkg.sv
// Shared definitions for the hex display page scheduler: FSM state encoding
// and the CPU byte-source slot numbers on src_bus.
package hex_page_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [2:0] SRC_MAR = 3'd0;
  localparam logic [2:0] SRC_AC  = 3'd1;
  localparam logic [2:0] SRC_R   = 3'd2;
  localparam logic [2:0] SRC_PC  = 3'd3;
  localparam logic [2:0] SRC_IR  = 3'd4;
  localparam logic [2:0] SRC_DR  = 3'd5;
  localparam logic [2:0] SRC_TR  = 3'd6;
  localparam logic [2:0] SRC_CHK = 3'd7;

endpackage

// File: rtl/hex_page_scheduler_key_sync_edge.sv
// Two-flop synchroniser for an active-low push-key plus a falling-edge pulse.
// The pulse is high for one cycle, two cycles after the key low is first sampled.
module key_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], key_n_i};
    end
  end

  // sync_q[2] is the previous synchronised level; a held key yields one pulse
  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/hex_page_scheduler.sv
// Rotates up to 8 CPU byte sources onto the two-digit hex display, with blanking gaps.
// Optional macro HEX_PAGE_CHANGE_FLASH_EN: pulse change_flag and restart dwell on value change.
module hex_page_scheduler
  import hex_page_pkg::*;
#(
  parameter int DWELL_CYC = 50,
  parameter int BLANK_CYC = 2,
  parameter int DW        = 8
) (
  input  logic            light_clk,
  input  logic            rst_n,
  input  logic            auto_en,
  input  logic            step_key_n,
  input  logic            hold,
  input  logic [8*DW-1:0] src_bus,
  input  logic [7:0]      src_valid,
  output logic [DW-1:0]   disp_byte,
  output logic [2:0]      page_idx,
  output logic            blank,
  output logic            page_change,
  output logic            change_flag
);

  localparam int DCW = $clog2(DWELL_CYC + 1);
  localparam int BCW = $clog2(BLANK_CYC + 1);

  state_e          state_q, state_d;
  logic [2:0]      page_q, page_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic            pc_q, pc_d;
  logic            flag_q, flag_d;
  logic [DCW-1:0]  dwell_q, dwell_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            auto_q;
  logic            step;
  logic            adv;
  logic            changed;
  logic [3:0]      nv;
  logic [DW-1:0]   cur_byte;

  key_sync_edge u_key (
    .clk_i   (light_clk),
    .rst_n_i (rst_n),
    .key_n_i (step_key_n),
    .fall_o  (step)
  );

  // {found, index} of the first valid source after cur, wrapping, never cur itself
  function automatic logic [3:0] next_valid(input logic [2:0] cur, input logic [7:0] v);
    logic [3:0] r;
    logic [2:0] j;
    r = 4'd0;
    for (int k = 7; k >= 1; k--) begin
      j = cur + 3'(k);
      if (v[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest_valid(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) r = 3'(k);
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    dwell_d  = dwell_q;
    bcnt_d   = bcnt_q;
    pc_d     = 1'b0;
    flag_d   = 1'b0;
    adv      = 1'b0;
    nv       = next_valid(page_q, src_valid);
    cur_byte = src_bus[int'(page_q)*DW +: DW];
`ifdef HEX_PAGE_CHANGE_FLASH_EN
    changed  = (cur_byte != disp_q);
`else
    changed  = 1'b0;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (|src_valid) begin
          page_d  = lowest_valid(src_valid);
          pc_d    = 1'b1;
          state_d = ST_BLANK;
          bcnt_d  = '0;
        end
      end
      ST_BLANK: begin
        if (!src_valid[page_q]) begin
          adv = 1'b1;
        end else if (bcnt_q == BCW'(BLANK_CYC - 1)) begin
          state_d = ST_SHOW;
          dwell_d = '0;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      ST_SHOW: begin
        if (!src_valid[page_q]) begin
          adv = 1'b1;
        end else if (!hold) begin
          flag_d = changed;
          if (auto_en != auto_q) begin
            dwell_d = '0;
          end else if (auto_en) begin
            if (changed) begin
              dwell_d = '0;
            end else if (dwell_q == DCW'(DWELL_CYC - 1)) begin
              adv = 1'b1;
            end else begin
              dwell_d = dwell_q + DCW'(1);
            end
          end else if (step) begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A sole still-valid page keeps showing with a fresh dwell instead of re-blanking
    if (adv) begin
      if (nv[3]) begin
        page_d  = nv[2:0];
        pc_d    = 1'b1;
        state_d = ST_BLANK;
        bcnt_d  = '0;
      end else if (src_valid[page_q]) begin
        state_d = ST_SHOW;
        dwell_d = '0;
      end else begin
        state_d = ST_EMPTY;
      end
    end

    disp_d = (state_d == ST_SHOW) ? src_bus[int'(page_d)*DW +: DW] : '0;
  end

  always_ff @(posedge light_clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      page_q  <= SRC_MAR;
      disp_q  <= '0;
      pc_q    <= 1'b0;
      flag_q  <= 1'b0;
      dwell_q <= '0;
      bcnt_q  <= '0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      disp_q  <= disp_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      auto_q  <= auto_en;
    end
  end

  assign disp_byte   = disp_q;
  assign page_idx    = page_q;
  assign blank       = (state_q != ST_SHOW);
  assign page_change = pc_q;
  assign change_flag = flag_q;

endmodule
